// File: rtl/hd_fu_sched.sv
// hd_fu_sched: shares one external bit-manipulation function unit (FU) among
// NREQ requesters. Round-robin arbitration with one operation in flight,
// valid/ready handshakes on both sides, and a timeout for FUs whose latency
// is variable or unbounded.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/ready     per-requester operand handshake (ready is one-hot or 0)
//   req_data            operand of requester i at [i*W +: W]
//   rsp_valid/ready     per-requester result handshake (valid is one-hot or 0)
//   rsp_data, rsp_err   shared result bus; rsp_err=1 means timeout, data 0
//   fu_x, fu_start      FU operand and one-cycle launch pulse
//   fu_y, fu_done       FU result and completion pulse
//   busy                scheduler is not idle
//   grant_id            index of the current/last granted requester
module hd_fu_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255,
  localparam int GW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  output logic [W-1:0]      fu_x,
  output logic              fu_start,
  input  logic [W-1:0]      fu_y,
  input  logic              fu_done,
  output logic              busy,
  output logic [GW-1:0]     grant_id
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [GW-1:0] ptr_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic [GW-1:0] winner_s;
  logic          found_s;
  logic          accept_s;
  logic          rsp_hs_s;
  logic          done_s;
  logic          tmo_s;
  logic [NREQ-1:0] onehot_s;

  // Round-robin search: first asserted req_valid after the pointer, wrapping.
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] idx;
    logic          take;
    winner_s = ptr_r;
    found_s  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sum      = {1'b0, ptr_r} + (GW+1)'(k);
      idx      = (sum >= (GW+1)'(NREQ)) ? GW'(sum - (GW+1)'(NREQ)) : GW'(sum);
      take     = !found_s && req_valid[idx];
      winner_s = take ? idx : winner_s;
      found_s  = found_s | take;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_ISSUE;
        else          state_s = ST_IDLE;
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s || tmo_s) state_s = ST_RESP;
        else                 state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_hs_s) state_s = ST_IDLE;
        else          state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output/strobe logic: req_ready is the only combinational output.
  // The counter's incremented value is compared so WAIT lasts exactly
  // TIMEOUT cycles and the counter stops at TIMEOUT as it leaves WAIT.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    accept_s  = 1'b0;
    cnt_inc_s = cnt_r + CW'(1);
    onehot_s  = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
    if (state_r == ST_IDLE && found_s) begin
      req_ready[winner_s] = 1'b1;
      accept_s            = 1'b1;
    end else begin
      accept_s            = 1'b0;
    end
    rsp_hs_s = (state_r == ST_RESP) && rsp_ready[grant_id];
    done_s   = (state_r == ST_WAIT) && fu_done;
    tmo_s    = (state_r == ST_WAIT) && !fu_done && (cnt_inc_s == CW'(TIMEOUT));
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r     <= GW'(NREQ - 1);
      grant_id  <= {GW{1'b0}};
      fu_x      <= {W{1'b0}};
      fu_start  <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      rsp_valid <= {NREQ{1'b0}};
      rsp_data  <= {W{1'b0}};
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      fu_start <= accept_s;
      busy     <= (state_s != ST_IDLE);
      if (accept_s) begin
        fu_x     <= req_data[winner_s*W +: W];
        grant_id <= winner_s;
      end
      if (state_r == ST_ISSUE) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_inc_s;
      end
      if (done_s) begin
        rsp_data  <= fu_y;
        rsp_err   <= 1'b0;
        rsp_valid <= onehot_s;
      end else if (tmo_s) begin
        rsp_data  <= {W{1'b0}};
        rsp_err   <= 1'b1;
        rsp_valid <= onehot_s;
      end else if (rsp_hs_s) begin
        rsp_valid <= {NREQ{1'b0}};
        ptr_r     <= grant_id;
      end
    end
  end

endmodule
